// File: rtl/mem_responder.sv
// Word-organised data memory behind a one-outstanding request/response handshake.
// Adds WAIT_CYCLES of latency and does byte/half/word lane steering with error checks.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_CAP  = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             mem_write;
    logic             access_err;
    logic             misaligned;
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [1:0]       cur_size;
    logic             cur_zext;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_word;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_ext;
    logic [3:0]       lane_be;
    logic [31:0]      lane_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            zext_q     <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Contents survive reset; only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // With zero wait states the access happens at the accept edge, so use live inputs in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
            cur_zext  = req_unsigned;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_zext  = zext_q;
        end
        offset   = cur_addr - BASE_ADDR;
        word_idx = offset[IDX_W+1:2];
        case (cur_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = cur_addr[0];
            2'b10:   misaligned = |cur_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        access_err = misaligned || ({1'b0, offset} >= BYTE_CAP);
    end

    always_comb begin
        mem_word = mem_q[word_idx];
        case (cur_addr[1:0])
            2'd0:    load_byte = mem_word[7:0];
            2'd1:    load_byte = mem_word[15:8];
            2'd2:    load_byte = mem_word[23:16];
            default: load_byte = mem_word[31:24];
        endcase
        load_half = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];
        case (cur_size)
            2'b00:   load_ext = cur_zext ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_ext = cur_zext ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_ext = mem_word;
        endcase
        case (cur_size)
            2'b00: begin
                lane_be   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                lane_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                lane_be   = 4'b1111;
                lane_data = cur_wdata;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = NO_WAIT ? ST_RESP : ST_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The response is captured exactly once, on the edge that enters RESP.
    always_comb begin
        accept     = req_valid && req_ready;
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
        mem_write  = enter_resp && !reset && cur_we && !access_err;
        we_d       = accept ? req_we       : we_q;
        addr_d     = accept ? req_addr     : addr_q;
        wdata_d    = accept ? req_wdata    : wdata_q;
        size_d     = accept ? req_size     : size_q;
        zext_d     = accept ? req_unsigned : zext_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (enter_resp) begin
            err_d   = access_err;
            rdata_d = (access_err || cur_we) ? 32'd0 : load_ext;
        end
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !reset;
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule
